// File: rtl/pay_dispense.sv
// pay_dispense: payment and dispense controller for the vending machine.
// It latches a selection from the commodity selector and collects coins until
// the latched price is covered. It then pulses dispense for one cycle and pays
// back change, one greedy coin per cycle. A cancel refunds everything paid.
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   goods_price/num      selection from the selector (num 0 = no selection)
//   coin_valid/sel       inserted coin (00=1, 01=2, 10=5, 11=10)
//   cancel               abort the purchase and refund
//   paid                 running amount inserted
//   busy                 high when not IDLE
//   coin_reject          one-cycle pulse, the cycle after a refused coin
//   dispense/_num        one-cycle release strobe with latched item number
//   change_valid/sel     one change coin per cycle
//
// state    | meaning
// IDLE     | waiting for a selection; coins refused
// PAY      | collecting coins toward the latched price
// DISPENSE | one-cycle item release; remaining change computed
// CHANGE   | paying back remaining, largest coin first
module pay_dispense #(
  parameter int PRICE_W = 8,
  parameter int NUM_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PRICE_W-1:0] goods_price,
  input  logic [NUM_W-1:0]   goods_num,
  input  logic               coin_valid,
  input  logic [1:0]         coin_sel,
  input  logic               cancel,
  output logic [PRICE_W-1:0] paid,
  output logic               busy,
  output logic               coin_reject,
  output logic               dispense,
  output logic [NUM_W-1:0]   dispense_num,
  output logic               change_valid,
  output logic [1:0]         change_sel
);

  typedef enum logic [1:0] {IDLE, PAY, DISPENSE, CHANGE} state_t;

  localparam logic [PRICE_W-1:0] V1  = PRICE_W'(1);
  localparam logic [PRICE_W-1:0] V2  = PRICE_W'(2);
  localparam logic [PRICE_W-1:0] V5  = PRICE_W'(5);
  localparam logic [PRICE_W-1:0] V10 = PRICE_W'(10);

  function automatic logic [PRICE_W-1:0] coin_value(input logic [1:0] sel);
    case (sel)
      2'b00:   coin_value = V1;
      2'b01:   coin_value = V2;
      2'b10:   coin_value = V5;
      default: coin_value = V10;
    endcase
  endfunction

  function automatic logic [1:0] greedy_sel(input logic [PRICE_W-1:0] amt);
    if (amt >= V10)     greedy_sel = 2'b11;
    else if (amt >= V5) greedy_sel = 2'b10;
    else if (amt >= V2) greedy_sel = 2'b01;
    else                greedy_sel = 2'b00;
  endfunction

  state_t             state_q, state_d;
  logic [PRICE_W-1:0] price_q, price_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [PRICE_W-1:0] paid_q, paid_d;
  logic [PRICE_W-1:0] remain_q, remain_d;
  logic               busy_q, busy_d;
  logic               coin_reject_q, coin_reject_d;
  logic               dispense_q, dispense_d;
  logic [NUM_W-1:0]   dispense_num_q, dispense_num_d;
  logic               change_valid_q, change_valid_d;
  logic [1:0]         change_sel_q, change_sel_d;

  logic [PRICE_W:0]   sum;
  logic               coin_ok;
  logic [PRICE_W-1:0] refund;
  logic               issue_en;
  logic [PRICE_W-1:0] issue_amt;
  logic [1:0]         issue_sel;

  // Extra carry bit detects a coin that would overflow paid.
  assign sum     = {1'b0, paid_q} + {1'b0, coin_value(coin_sel)};
  assign coin_ok = coin_valid && (state_q == PAY) && !sum[PRICE_W];

  always_comb begin
    state_d        = state_q;
    price_d        = price_q;
    num_d          = num_q;
    paid_d         = paid_q;
    remain_d       = remain_q;
    coin_reject_d  = coin_valid && !coin_ok;
    dispense_d     = 1'b0;
    dispense_num_d = '0;
    change_valid_d = 1'b0;
    change_sel_d   = 2'b00;
    refund         = '0;
    issue_en       = 1'b0;
    issue_amt      = '0;
    issue_sel      = 2'b00;

    case (state_q)
      IDLE: begin
        if (goods_num != '0 && goods_price != '0) begin
          price_d = goods_price;
          num_d   = goods_num;
          paid_d  = '0;
          state_d = PAY;
        end
      end
      PAY: begin
        if (coin_ok) paid_d = sum[PRICE_W-1:0];
        if (cancel) begin
          refund = paid_d;
          if (refund == '0) begin
            state_d = IDLE;
          end else begin
            state_d   = CHANGE;
            issue_en  = 1'b1;
            issue_amt = refund;
          end
        end else if (paid_d >= price_q) begin
          state_d        = DISPENSE;
          dispense_d     = 1'b1;
          dispense_num_d = num_q;
        end
      end
      DISPENSE: begin
        refund = paid_q - price_q;
        if (refund == '0) begin
          state_d = IDLE;
        end else begin
          state_d   = CHANGE;
          issue_en  = 1'b1;
          issue_amt = refund;
        end
      end
      default: begin
        // remain_q already excludes the coin shown this cycle.
        if (remain_q != '0) begin
          issue_en  = 1'b1;
          issue_amt = remain_q;
        end else begin
          state_d = IDLE;
          paid_d  = '0;
        end
      end
    endcase

    // Change outputs are registered, so the coin for the amount entering
    // (or staying in) CHANGE is chosen here and remain holds what is left.
    if (issue_en) begin
      issue_sel      = greedy_sel(issue_amt);
      change_valid_d = 1'b1;
      change_sel_d   = issue_sel;
      remain_d       = issue_amt - coin_value(issue_sel);
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      price_q        <= '0;
      num_q          <= '0;
      paid_q         <= '0;
      remain_q       <= '0;
      busy_q         <= 1'b0;
      coin_reject_q  <= 1'b0;
      dispense_q     <= 1'b0;
      dispense_num_q <= '0;
      change_valid_q <= 1'b0;
      change_sel_q   <= 2'b00;
    end else begin
      state_q        <= state_d;
      price_q        <= price_d;
      num_q          <= num_d;
      paid_q         <= paid_d;
      remain_q       <= remain_d;
      busy_q         <= busy_d;
      coin_reject_q  <= coin_reject_d;
      dispense_q     <= dispense_d;
      dispense_num_q <= dispense_num_d;
      change_valid_q <= change_valid_d;
      change_sel_q   <= change_sel_d;
    end
  end

  assign paid         = paid_q;
  assign busy         = busy_q;
  assign coin_reject  = coin_reject_q;
  assign dispense     = dispense_q;
  assign dispense_num = dispense_num_q;
  assign change_valid = change_valid_q;
  assign change_sel   = change_sel_q;

endmodule

// File: tb/tb_pay_dispense.sv
// Directed testbench for pay_dispense: reset, exact pay, overpay with change,
// cancel refund, coin rejects and asynchronous reset during change.
module tb_pay_dispense;

  logic       clk;
  logic       rst;
  logic [7:0] goods_price;
  logic [3:0] goods_num;
  logic       coin_valid;
  logic [1:0] coin_sel;
  logic       cancel;
  logic [7:0] paid;
  logic       busy;
  logic       coin_reject;
  logic       dispense;
  logic [3:0] dispense_num;
  logic       change_valid;
  logic [1:0] change_sel;

  int n_checks = 0;
  int n_errors = 0;

  pay_dispense #(.PRICE_W(8), .NUM_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .goods_price  (goods_price),
    .goods_num    (goods_num),
    .coin_valid   (coin_valid),
    .coin_sel     (coin_sel),
    .cancel       (cancel),
    .paid         (paid),
    .busy         (busy),
    .coin_reject  (coin_reject),
    .dispense     (dispense),
    .dispense_num (dispense_num),
    .change_valid (change_valid),
    .change_sel   (change_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic select(input logic [3:0] num, input logic [7:0] price);
    goods_num   = num;
    goods_price = price;
    step();
    goods_num   = 4'd0;
    goods_price = 8'd0;
  endtask

  task automatic coin(input logic [1:0] sel);
    coin_valid = 1'b1;
    coin_sel   = sel;
  endtask

  initial begin
    rst         = 1'b0;
    goods_price = 8'd4;
    goods_num   = 4'd3;
    coin_valid  = 1'b1;
    coin_sel    = 2'b11;
    cancel      = 1'b0;

    // Reset held with a coin and a selection present
    repeat (3) step();
    check("rst_paid",   32'(paid), 0);
    check("rst_busy",   32'(busy), 0);
    check("rst_reject", 32'(coin_reject), 0);
    check("rst_disp",   32'(dispense), 0);
    check("rst_dnum",   32'(dispense_num), 0);
    check("rst_cv",     32'(change_valid), 0);
    check("rst_csel",   32'(change_sel), 0);

    rst        = 1'b1;
    coin_valid = 1'b0;
    step();
    check("rel_busy", 32'(busy), 1);
    goods_num   = 4'd0;
    goods_price = 8'd0;
    coin(2'b10);
    step();
    check("rel_disp", 32'(dispense), 1);
    check("rel_dnum", 32'(dispense_num), 3);
    check("rel_paid", 32'(paid), 5);
    coin_valid = 1'b0;
    step();
    check("rel_cv",   32'(change_valid), 1);
    check("rel_csel", 32'(change_sel), 0);
    step();
    check("rel_idle_cv",   32'(change_valid), 0);
    check("rel_idle_busy", 32'(busy), 0);
    check("rel_idle_paid", 32'(paid), 0);

    // Exact pay: price 7 with 5 + 2
    select(4'd1, 8'd7);
    check("ex_busy", 32'(busy), 1);
    coin(2'b10);
    step();
    check("ex_paid5", 32'(paid), 5);
    check("ex_nodisp", 32'(dispense), 0);
    coin(2'b01);
    step();
    check("ex_paid7", 32'(paid), 7);
    check("ex_disp", 32'(dispense), 1);
    check("ex_dnum", 32'(dispense_num), 1);
    coin_valid = 1'b0;
    step();
    check("ex_disp_off", 32'(dispense), 0);
    check("ex_cv",       32'(change_valid), 0);
    check("ex_busy_off", 32'(busy), 0);

    // Overpay: price 3 with one 10 -> change 5, 2
    select(4'd2, 8'd3);
    coin(2'b11);
    step();
    check("ov_disp", 32'(dispense), 1);
    check("ov_dnum", 32'(dispense_num), 2);
    check("ov_paid", 32'(paid), 10);
    coin_valid = 1'b0;
    step();
    check("ov_cv1",   32'(change_valid), 1);
    check("ov_csel1", 32'(change_sel), 2);
    check("ov_disp_off", 32'(dispense), 0);
    step();
    check("ov_cv2",   32'(change_valid), 1);
    check("ov_csel2", 32'(change_sel), 1);
    step();
    check("ov_cv_off", 32'(change_valid), 0);
    check("ov_busy",   32'(busy), 0);
    check("ov_paid0",  32'(paid), 0);

    // Cancel with a same-cycle coin: refund 2+2+1 = 5 as a single coin
    select(4'd4, 8'd9);
    coin(2'b01);
    step();
    check("cn_paid2", 32'(paid), 2);
    step();
    check("cn_paid4", 32'(paid), 4);
    coin(2'b00);
    cancel = 1'b1;
    step();
    coin_valid = 1'b0;
    cancel     = 1'b0;
    check("cn_disp", 32'(dispense), 0);
    check("cn_cv",   32'(change_valid), 1);
    check("cn_csel", 32'(change_sel), 2);
    check("cn_paid5", 32'(paid), 5);
    step();
    check("cn_cv_off", 32'(change_valid), 0);
    check("cn_disp2",  32'(dispense), 0);
    check("cn_busy",   32'(busy), 0);
    check("cn_paid0",  32'(paid), 0);

    // Cancel with nothing paid goes straight back to IDLE
    select(4'd7, 8'd5);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cz_busy", 32'(busy), 0);
    check("cz_cv",   32'(change_valid), 0);

    // Coin in IDLE is refused
    coin(2'b11);
    step();
    coin_valid = 1'b0;
    check("rj_idle_pulse", 32'(coin_reject), 1);
    check("rj_idle_paid",  32'(paid), 0);
    step();
    check("rj_idle_clear", 32'(coin_reject), 0);

    // Overflow reject at paid 250, price 255
    select(4'd5, 8'd255);
    coin(2'b11);
    repeat (25) step();
    check("rj_paid250", 32'(paid), 250);
    check("rj_nodisp",  32'(dispense), 0);
    step();
    check("rj_ovf_pulse", 32'(coin_reject), 1);
    check("rj_ovf_paid",  32'(paid), 250);
    coin(2'b10);
    step();
    coin_valid = 1'b0;
    check("rj_paid255",   32'(paid), 255);
    check("rj_disp",      32'(dispense), 1);
    check("rj_dnum",      32'(dispense_num), 5);
    check("rj_no_reject", 32'(coin_reject), 0);
    step();
    check("rj_cv",   32'(change_valid), 0);
    check("rj_busy", 32'(busy), 0);

    // Asynchronous reset during change
    select(4'd6, 8'd1);
    coin(2'b11);
    step();
    coin_valid = 1'b0;
    check("ar_disp", 32'(dispense), 1);
    step();
    check("ar_cv",   32'(change_valid), 1);
    check("ar_csel", 32'(change_sel), 2);
    #2 rst = 1'b0;
    #1;
    check("ar_cv_drop", 32'(change_valid), 0);
    check("ar_busy",    32'(busy), 0);
    check("ar_csel0",   32'(change_sel), 0);
    check("ar_paid",    32'(paid), 0);
    step();
    rst = 1'b1;
    step();
    check("ar_post_cv",   32'(change_valid), 0);
    check("ar_post_busy", 32'(busy), 0);
    step();
    check("ar_post_cv2",  32'(change_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
